// File: rtl/compare_operand_loader.sv
// ---------------------------------------------------------------------------
// compare_operand_loader
//
// Front/back end for the external combinational 3-bit magnitude comparator.
// Operand A and then operand B are captured from one shared switch bus on
// successive presses of the load button and driven to the comparator. One
// cycle after B is captured, the comparator's G/E/L answer is registered, and
// a saturating tally of each outcome is kept for the LED / 7-seg display.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   din        operand switch bus (W bits), sampled only on a load press
//   load       debounced, clk-synchronous load button (level)
//   clr        synchronous clear of tallies, results and operand sequence
//   cmp_g/e/l  comparator answer for a_out vs b_out
//   a_out      registered operand A, to comparator A input
//   b_out      registered operand B, to comparator B input
//   res_g/e/l  latched comparator answer
//   res_valid  res_g/e/l hold the answer for the current a_out/b_out pair
//   err        sticky flag: a sampled comparator answer was not one-hot
//   state      current FSM state, for LEDs
//   cnt_g/e/l  saturating tallies of G, E and L outcomes (CW bits each)
// ---------------------------------------------------------------------------
module compare_operand_loader #(
  parameter int W  = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  din,
  input  logic          load,
  input  logic          clr,
  input  logic          cmp_g,
  input  logic          cmp_e,
  input  logic          cmp_l,
  output logic [W-1:0]  a_out,
  output logic [W-1:0]  b_out,
  output logic          res_g,
  output logic          res_e,
  output logic          res_l,
  output logic          res_valid,
  output logic          err,
  output logic [1:0]    state,
  output logic [CW-1:0] cnt_g,
  output logic [CW-1:0] cnt_e,
  output logic [CW-1:0] cnt_l
);

  localparam logic [1:0] S_A    = 2'd0;
  localparam logic [1:0] S_B    = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic load_d;
  logic ld;
  logic one_hot;
  logic sample;

  // A press is the rising edge of the level button; holding it gives one ld.
  assign ld = load & ~load_d;

  // The comparator answer is only trusted when exactly one flag is set.
  always_comb begin
    one_hot = 1'b0;
    case ({cmp_g, cmp_e, cmp_l})
      3'b100, 3'b010, 3'b001: one_hot = 1'b1;
      default:                one_hot = 1'b0;
    endcase
  end

  // The compare cycle is the only cycle in which results and tallies move.
  assign sample = (state == S_CMP);

  // load_d keeps tracking the button even during clr, so a button held
  // through a clear does not fire again once clr drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_d <= 1'b0;
    end else begin
      load_d <= load;
    end
  end

  // Operand sequencing and result latches. S_CMP lasts exactly one cycle so
  // the comparator has seen stable a_out/b_out for a full cycle before its
  // answer is captured; presses during that cycle are dropped. From S_DONE a
  // press loads a fresh A and goes straight to waiting for B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_A;
      a_out     <= '0;
      b_out     <= '0;
      res_g     <= 1'b0;
      res_e     <= 1'b0;
      res_l     <= 1'b0;
      res_valid <= 1'b0;
    end else if (clr) begin
      state     <= S_A;
      a_out     <= '0;
      b_out     <= '0;
      res_g     <= 1'b0;
      res_e     <= 1'b0;
      res_l     <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_A: begin
          if (ld) begin
            a_out <= din;
            state <= S_B;
          end
        end
        S_B: begin
          if (ld) begin
            b_out <= din;
            state <= S_CMP;
          end
        end
        S_CMP: begin
          res_g     <= cmp_g;
          res_e     <= cmp_e;
          res_l     <= cmp_l;
          res_valid <= 1'b1;
          state     <= S_DONE;
        end
        default: begin
          if (ld) begin
            a_out     <= din;
            res_g     <= 1'b0;
            res_e     <= 1'b0;
            res_l     <= 1'b0;
            res_valid <= 1'b0;
            state     <= S_B;
          end
        end
      endcase
    end
  end

  // Outcome tallies and the sticky error flag. A malformed answer raises err
  // and leaves every tally untouched; a full tally holds at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_g <= '0;
      cnt_e <= '0;
      cnt_l <= '0;
      err   <= 1'b0;
    end else if (clr) begin
      cnt_g <= '0;
      cnt_e <= '0;
      cnt_l <= '0;
      err   <= 1'b0;
    end else if (sample) begin
      if (!one_hot) begin
        err <= 1'b1;
      end else if (cmp_g) begin
        if (cnt_g != CNT_MAX) cnt_g <= cnt_g + CNT_ONE;
      end else if (cmp_e) begin
        if (cnt_e != CNT_MAX) cnt_e <= cnt_e + CNT_ONE;
      end else begin
        if (cnt_l != CNT_MAX) cnt_l <= cnt_l + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_compare_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_compare_operand_loader
//
// Bench for compare_operand_loader. The external comparator is emulated from
// a_out/b_out (with an override that produces a malformed answer). Every B
// press pushes the expected result into a scoreboard queue; a separate
// monitor pops and compares whenever res_valid rises. Directed checks cover
// reset, held button, saturation, error flag, clear and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_compare_operand_loader;

  localparam int W  = 3;
  localparam int CW = 4;
  localparam int CNT_LIMIT = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  din;
  logic          load;
  logic          clr;
  logic          cmp_g, cmp_e, cmp_l;
  logic [W-1:0]  a_out, b_out;
  logic          res_g, res_e, res_l, res_valid, err;
  logic [1:0]    state;
  logic [CW-1:0] cnt_g, cnt_e, cnt_l;

  logic forceBad;

  compare_operand_loader #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .load      (load),
    .clr       (clr),
    .cmp_g     (cmp_g),
    .cmp_e     (cmp_e),
    .cmp_l     (cmp_l),
    .a_out     (a_out),
    .b_out     (b_out),
    .res_g     (res_g),
    .res_e     (res_e),
    .res_l     (res_l),
    .res_valid (res_valid),
    .err       (err),
    .state     (state),
    .cnt_g     (cnt_g),
    .cnt_e     (cnt_e),
    .cnt_l     (cnt_l)
  );

  // Emulated combinational comparator; forceBad gives G and L together.
  assign cmp_g = forceBad ? 1'b1 : (a_out > b_out);
  assign cmp_e = forceBad ? 1'b0 : (a_out == b_out);
  assign cmp_l = forceBad ? 1'b1 : (a_out < b_out);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       g, e, l, errFlag;
    int         cg, ce, cl;
    logic [2:0] a, b;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: operands and running tallies in plain integers.
  int   modelA, modelB;
  int   modelG, modelE, modelL;
  logic modelErr;
  logic prevValid;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int satInc(input int v);
    return (v >= CNT_LIMIT) ? CNT_LIMIT : v + 1;
  endfunction

  // One press: drive din and raise load at a falling edge, keep it high for
  // holdCycles cycles, then release and scramble din.
  task automatic applyStimulus(input int value, input int holdCycles);
    @(negedge clk);
    din  = value[W-1:0];
    load = 1'b1;
    repeat (holdCycles) @(negedge clk);
    load = 1'b0;
    din  = W'($urandom_range(0, 7));
  endtask

  task automatic pressA(input int value);
    applyStimulus(value, 1);
    modelA = value;
    checkOutput("a_capture", a_out, value);
    checkOutput("state_after_a", state, 1);
    checkOutput("valid_after_a", res_valid, 0);
  endtask

  task automatic pressB(input int value);
    exp_t e;
    modelB = value;
    if (forceBad) begin
      e.g = 1'b1; e.e = 1'b0; e.l = 1'b1;
      modelErr = 1'b1;
    end else begin
      e.g = (modelA > modelB);
      e.e = (modelA == modelB);
      e.l = (modelA < modelB);
      if (e.g) modelG = satInc(modelG);
      if (e.e) modelE = satInc(modelE);
      if (e.l) modelL = satInc(modelL);
    end
    e.errFlag = modelErr;
    e.cg = modelG; e.ce = modelE; e.cl = modelL;
    e.a = modelA[2:0]; e.b = modelB[2:0];
    expQ.push_back(e);
    applyStimulus(value, 1);
    checkOutput("state_cmp", state, 2);
    checkOutput("valid_in_cmp", res_valid, 0);
    @(negedge clk);
    checkOutput("valid_latency", res_valid, 1);
    checkOutput("state_done", state, 3);
  endtask

  task automatic doPair(input int a, input int b, input int gap);
    pressA(a);
    pressB(b);
    repeat (gap) @(negedge clk);
  endtask

  task automatic doClear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    modelG = 0; modelE = 0; modelL = 0; modelErr = 1'b0;
    checkOutput("clr_state", state, 0);
    checkOutput("clr_err", err, 0);
    checkOutput("clr_cnt_g", cnt_g, 0);
    checkOutput("clr_cnt_e", cnt_e, 0);
    checkOutput("clr_cnt_l", cnt_l, 0);
    checkOutput("clr_a", a_out, 0);
    checkOutput("clr_b", b_out, 0);
    checkOutput("clr_valid", res_valid, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_a"}, a_out, 0);
    checkOutput({tag, "_b"}, b_out, 0);
    checkOutput({tag, "_res"}, {res_g, res_e, res_l}, 0);
    checkOutput({tag, "_valid"}, res_valid, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_state"}, state, 0);
    checkOutput({tag, "_cnt"}, {cnt_g, cnt_e, cnt_l}, 0);
  endtask

  // Scoreboard monitor: each rising res_valid consumes one expected entry.
  always @(negedge clk) begin
    if (res_valid && !prevValid) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_result: got res_valid 1, expected no result");
      end else begin
        monExp = expQ.pop_front();
        checkOutput("sb_res_g", res_g, monExp.g);
        checkOutput("sb_res_e", res_e, monExp.e);
        checkOutput("sb_res_l", res_l, monExp.l);
        checkOutput("sb_err", err, monExp.errFlag);
        checkOutput("sb_cnt_g", cnt_g, monExp.cg);
        checkOutput("sb_cnt_e", cnt_e, monExp.ce);
        checkOutput("sb_cnt_l", cnt_l, monExp.cl);
        checkOutput("sb_a", a_out, monExp.a);
        checkOutput("sb_b", b_out, monExp.b);
      end
    end
    prevValid = res_valid;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    prevValid = 1'b0;
    forceBad  = 1'b0;
    din = '0; load = 1'b0; clr = 1'b0;
    modelA = 0; modelB = 0; modelG = 0; modelE = 0; modelL = 0;
    modelErr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    // Directed pairs: G, E, L outcomes.
    doPair(5, 3, 1);
    checkOutput("pair1_a", a_out, 5);
    checkOutput("pair1_b", b_out, 3);
    doPair(2, 2, 1);
    doPair(1, 6, 1);

    // Held button: only one press seen, only A captured.
    applyStimulus(7, 20);
    modelA = 7;
    checkOutput("hold_a", a_out, 7);
    checkOutput("hold_state", state, 1);
    checkOutput("hold_b", b_out, 6);
    repeat (2) @(negedge clk);
    checkOutput("hold_state_later", state, 1);
    pressB(4);

    // Randomized pairs with random idle gaps.
    for (int i = 0; i < 15; i++) begin
      doPair($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
    end

    // Saturation of the G tally.
    doClear();
    for (int i = 0; i < 17; i++) doPair(4, 1, 0);
    @(negedge clk);
    checkOutput("sat_cnt_g", cnt_g, CNT_LIMIT);
    checkOutput("sat_cnt_e", cnt_e, 0);
    checkOutput("sat_cnt_l", cnt_l, 0);

    // Malformed comparator answer: err sticks, tallies frozen.
    doClear();
    doPair(3, 5, 0);
    pressA(2);
    forceBad = 1'b1;
    pressB(2);
    forceBad = 1'b0;
    doPair(6, 0, 1);
    checkOutput("err_sticky", err, 1);
    doClear();

    // Clear coinciding with a press: press dropped, no re-fire on release.
    doPair(3, 3, 0);
    @(negedge clk);
    clr = 1'b1; load = 1'b1; din = 3'd5;
    @(negedge clk);
    clr = 1'b0;
    modelG = 0; modelE = 0; modelL = 0; modelErr = 1'b0;
    repeat (3) @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    checkOutput("clr_ld_state", state, 0);
    checkOutput("clr_ld_a", a_out, 0);
    checkOutput("clr_ld_cnt_e", cnt_e, 0);

    // Asynchronous reset in the middle of S_B.
    pressA(6);
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    modelG = 0; modelE = 0; modelL = 0; modelErr = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_state", state, 0);
    pressA(5);
    pressB(2);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
